ifmap_packer: RTL and testbench
===============================

IFMAP_PACKER -- requirements
Module: ifmap_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the pixel width.
REQ-002 SHALL have parameter PAR_WRITE, default 14, meaning the number of tagged words per buffer write beat.
REQ-003 SHALL have parameter ROW_LEN_SIZE, default 5, meaning the width of the row-length and row-count configuration.
REQ-004 SHALL derive WORD_WIDTH = DATA_WIDTH + 2 as the tagged word width (18 at defaults).
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  one-cycle request to begin packing an image.
REQ-008 row_len  in  ROW_LEN_SIZE  pixels per row; sampled at start.
REQ-009 row_cnt  in  ROW_LEN_SIZE  rows per image; sampled at start.
REQ-010 pixel_in  in  DATA_WIDTH  pixel data.
REQ-011 pixel_valid  in  1  pixel_in is valid.
REQ-012 pixel_ready  out  1  packer accepts a pixel this cycle.
REQ-013 buf_full  in  1  the downstream IFMap buffer cannot accept a beat.
REQ-014 IFMap_out  out  WORD_WIDTH*PAR_WRITE  packed beat; slot 0 in the least-significant bits.
REQ-015 wen_IFMap_buffer  out  1  one-cycle write strobe for IFMap_out.
REQ-016 wr_count  out  clog2(PAR_WRITE+1)  number of valid slots in the current beat.
REQ-017 done  out  1  one-cycle pulse after the last beat is written.
REQ-018 err  out  1  sticky protocol error flag (see Configuration).

Function
REQ-019 SHALL implement states IDLE, FILL, WRITE and DONE.
REQ-020 IDLE -> FILL on start with row_len>=1 and row_cnt>=1, latching both values; a start with either value at zero SHALL be ignored.
REQ-021 In FILL, pixel_ready SHALL be 1, and each accepted pixel (valid && ready) SHALL be stored in the next slot with its tag.
REQ-022 Tag (bits [WORD_WIDTH-1:DATA_WIDTH]) SHALL be 2'b10 for the first pixel of a row, 2'b01 for the last, 2'b00 otherwise, and 2'b11 when row_len=1.
REQ-023 FILL -> WRITE when the accepted pixel fills slot PAR_WRITE-1 or is the last pixel of the image.
REQ-024 In WRITE, pixel_ready SHALL be 0 and wen_IFMap_buffer SHALL be asserted exactly while buf_full=0; the first assertion SHALL occur the cycle after the beat-completing pixel is accepted.
REQ-025 On the cycle wen_IFMap_buffer is asserted, the state SHALL move to FILL, or to DONE if the beat held the last pixel, and the slot index and wr_count SHALL clear.
REQ-026 Unused slots of a partial final beat SHALL read zero; wr_count SHALL equal the number of filled slots.
REQ-027 IFMap_out SHALL hold stable throughout WRITE, including while stalled by buf_full.
REQ-028 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-029 A row may span two beats; tags SHALL follow the pixel's position in the image, not its position in the beat.
REQ-030 start outside IDLE SHALL be ignored.
REQ-031 Peak throughput SHALL be PAR_WRITE pixels per PAR_WRITE+1 cycles.

Reset
REQ-032 rst SHALL force state IDLE, all counters and slots to 0, and pixel_ready, wen_IFMap_buffer, done, err, IFMap_out and wr_count to 0, immediately and asynchronously, including mid-image.

Configuration
REQ-033 With IFMAP_PACKER_ERR_EN defined, err SHALL set and hold until reset on pixel_valid in IDLE or DONE, or on start outside IDLE.
REQ-034 Without IFMAP_PACKER_ERR_EN, err SHALL be tied to 0 and those events SHALL be silently ignored.

Structure
REQ-035 A shared package ifmap_pkg SHALL hold the tag constants (TAG_MID=2'b00, TAG_END=2'b01, TAG_START=2'b10, TAG_SINGLE=2'b11) and the packer state enum.
REQ-036 The position/tag counter SHALL be a sub-module ifmap_tag_gen that tracks column and row and outputs the tag and a last-of-image flag.

Verification
REQ-037 Full beat: row_len=7, row_cnt=2, pixels 1..14 back-to-back -> one wen beat with slot0={10,1}, slot6={01,7}, slot7={10,8}, slot13={01,14}, wr_count=14, then done pulse.
REQ-038 Partial final beat: row_len=4, row_cnt=4 -> beats of 14 and 2 words, the second with slots 2..13 zero and wr_count=2.
REQ-039 Backpressure: buf_full=1 for 5 cycles in WRITE -> wen_IFMap_buffer=0, pixel_ready=0, IFMap_out stable; wen asserts the cycle buf_full falls.
REQ-040 row_len=1, row_cnt=3 -> three words all tagged 2'b11 in one beat.
REQ-041 rst asserted after 5 pixels -> all outputs 0 immediately; a fresh start then repacks correctly from slot 0.
REQ-042 With IFMAP_PACKER_ERR_EN: pixel_valid in IDLE -> err=1 held until rst; without the macro, err stays 0.

Source files
------------

// File: rtl/ifmap_pkg.sv
// Shared definitions for the IFMap packer: word tags and the packer state encoding.
package ifmap_pkg;

  localparam logic [1:0] TAG_MID    = 2'b00;
  localparam logic [1:0] TAG_END    = 2'b01;
  localparam logic [1:0] TAG_START  = 2'b10;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } packer_state_t;

  // The tag bits are simply {first-of-row, last-of-row}, so a one-pixel row becomes TAG_SINGLE.
  function automatic logic [1:0] make_tag(input logic first, input logic last);
    return {first, last};
  endfunction

endpackage

// File: rtl/ifmap_packer_if.sv
// Pixel-stream and buffer-write signals between the IFMap packer and its environment.
interface ifmap_packer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PAR_WRITE  = 14
);
  localparam int WORD_WIDTH  = DATA_WIDTH + 2;
  localparam int COUNT_WIDTH = $clog2(PAR_WRITE + 1);

  logic [DATA_WIDTH-1:0]            pixel_in;
  logic                             pixel_valid;
  logic                             pixel_ready;
  logic                             buf_full;
  logic [WORD_WIDTH*PAR_WRITE-1:0]  IFMap_out;
  logic                             wen_IFMap_buffer;
  logic [COUNT_WIDTH-1:0]           wr_count;

  modport master (
    output pixel_in, pixel_valid, buf_full,
    input  pixel_ready, IFMap_out, wen_IFMap_buffer, wr_count
  );

  modport slave (
    input  pixel_in, pixel_valid, buf_full,
    output pixel_ready, IFMap_out, wen_IFMap_buffer, wr_count
  );
endinterface

// File: rtl/ifmap_tag_gen.sv
// Tracks column/row of the next pixel within the image and produces its tag and a last-of-image flag.
module ifmap_tag_gen
  import ifmap_pkg::*;
#(
  parameter int ROW_LEN_SIZE = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    advance,
  input  logic [ROW_LEN_SIZE-1:0] row_len,
  input  logic [ROW_LEN_SIZE-1:0] row_cnt,
  output logic [1:0]              tag,
  output logic                    image_last
);

  logic [ROW_LEN_SIZE-1:0] len_q;
  logic [ROW_LEN_SIZE-1:0] cnt_q;
  logic [ROW_LEN_SIZE-1:0] col;
  logic [ROW_LEN_SIZE-1:0] row;
  logic                    col_last;

  assign col_last   = (col == len_q - ROW_LEN_SIZE'(1));
  assign tag        = make_tag(col == '0, col_last);
  assign image_last = col_last && (row == cnt_q - ROW_LEN_SIZE'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      cnt_q <= '0;
      col   <= '0;
      row   <= '0;
    end else if (load) begin
      len_q <= row_len;
      cnt_q <= row_cnt;
      col   <= '0;
      row   <= '0;
    end else if (advance) begin
      if (col_last) begin
        col <= '0;
        row <= row + ROW_LEN_SIZE'(1);
      end else begin
        col <= col + ROW_LEN_SIZE'(1);
      end
    end
  end

endmodule

// File: rtl/ifmap_packer.sv
// Packs tagged pixels into PAR_WRITE-word beats for the IFMap buffer.
// Define IFMAP_PACKER_ERR_EN to enable the sticky protocol error flag.
module ifmap_packer
  import ifmap_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int PAR_WRITE    = 14,
  parameter int ROW_LEN_SIZE = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ROW_LEN_SIZE-1:0] row_len,
  input  logic [ROW_LEN_SIZE-1:0] row_cnt,
  output logic                    done,
  output logic                    err,
  ifmap_packer_if.slave           bus
);

  localparam int WORD_WIDTH  = DATA_WIDTH + 2;
  localparam int COUNT_WIDTH = $clog2(PAR_WRITE + 1);
  localparam int SLOT_WIDTH  = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1;

  packer_state_t                   state;
  packer_state_t                   next_state;
  logic [SLOT_WIDTH-1:0]           slot_idx;
  logic [COUNT_WIDTH-1:0]          fill_count;
  logic [WORD_WIDTH-1:0]           slots [PAR_WRITE];
  logic [WORD_WIDTH*PAR_WRITE-1:0] packed_beat;
  logic                            beat_last;
  logic                            load;
  logic                            accept;
  logic                            beat_full;
  logic                            ready;
  logic                            wen;
  logic                            done_pulse;
  logic [1:0]                      tag;
  logic                            image_last;

  assign load      = (state == IDLE) && start && (row_len != '0) && (row_cnt != '0);
  assign accept    = (state == FILL) && bus.pixel_valid;
  assign beat_full = (slot_idx == SLOT_WIDTH'(PAR_WRITE - 1));

  ifmap_tag_gen #(
    .ROW_LEN_SIZE (ROW_LEN_SIZE)
  ) u_tag_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .advance    (accept),
    .row_len    (row_len),
    .row_cnt    (row_cnt),
    .tag        (tag),
    .image_last (image_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    wen        = 1'b0;
    done_pulse = 1'b0;
    case (state)
      IDLE: if (load) next_state = FILL;
      FILL: begin
        ready = 1'b1;
        if (accept && (beat_full || image_last)) next_state = WRITE;
      end
      WRITE: begin
        wen = !bus.buf_full;
        if (!bus.buf_full) next_state = beat_last ? DONE : FILL;
      end
      DONE: begin
        done_pulse = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Slots are zeroed after every write so a short final beat reads zero above wr_count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_idx   <= '0;
      fill_count <= '0;
      beat_last  <= 1'b0;
      for (int i = 0; i < PAR_WRITE; i++) slots[i] <= '0;
    end else begin
      if (load) beat_last <= 1'b0;
      if (accept) begin
        slots[slot_idx] <= {tag, bus.pixel_in};
        slot_idx        <= slot_idx + SLOT_WIDTH'(1);
        fill_count      <= fill_count + COUNT_WIDTH'(1);
        if (image_last) beat_last <= 1'b1;
      end
      if (wen) begin
        slot_idx   <= '0;
        fill_count <= '0;
        beat_last  <= 1'b0;
        for (int i = 0; i < PAR_WRITE; i++) slots[i] <= '0;
      end
    end
  end

  always_comb begin
    packed_beat = '0;
    for (int i = 0; i < PAR_WRITE; i++) packed_beat[i*WORD_WIDTH +: WORD_WIDTH] = slots[i];
  end

  assign bus.pixel_ready      = ready;
  assign bus.wen_IFMap_buffer = wen;
  assign bus.IFMap_out        = packed_beat;
  assign bus.wr_count         = fill_count;
  assign done                 = done_pulse;

`ifdef IFMAP_PACKER_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if ((bus.pixel_valid && (state == IDLE || state == DONE)) || (start && state != IDLE))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ifmap_packer.sv
// Self-checking bench for ifmap_packer: vector table, directed corner cases and a random phase
// checked against a reference packing model.
module tb_ifmap_packer;

  localparam int DW  = 16;
  localparam int PW  = 14;
  localparam int RLS = 5;
  localparam int WW  = DW + 2;
  localparam int BW  = WW * PW;
`ifdef IFMAP_PACKER_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  typedef struct {
    logic [BW-1:0] data;
    int            count;
  } beat_t;

  typedef struct {
    int len;
    int cnt;
    int exp_beats;
    int exp_last_count;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [RLS-1:0] row_len;
  logic [RLS-1:0] row_cnt;
  logic           done;
  logic           err;

  beat_t          exp_q[$];
  logic [DW-1:0]  pix_q[$];
  int             checks = 0;
  int             errors = 0;
  int             beats_seen;
  int             done_seen;
  int             last_count;
  logic [BW-1:0]  first_beat;
  logic [BW-1:0]  last_beat;
  bit             rand_bp = 1'b0;

  ifmap_packer_if #(.DATA_WIDTH(DW), .PAR_WRITE(PW)) bus ();

  ifmap_packer #(
    .DATA_WIDTH   (DW),
    .PAR_WRITE    (PW),
    .ROW_LEN_SIZE (RLS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .row_len (row_len),
    .row_cnt (row_cnt),
    .done    (done),
    .err     (err),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [BW-1:0] actual, input logic [BW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Every written beat is compared against the next beat the model predicted.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_seen++;
      if (bus.wen_IFMap_buffer) begin : pop_beat
        beat_t e;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_data", bus.IFMap_out, e.data);
          checkOutput("beat_count", BW'(bus.wr_count), BW'(e.count));
        end
        if (beats_seen == 0) first_beat = bus.IFMap_out;
        last_beat  = bus.IFMap_out;
        last_count = int'(bus.wr_count);
        beats_seen++;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      bus.buf_full = ($urandom_range(0, 3) == 0);
    end
  end

  // Reference: pixel k sits at column k % len; words are chunked PW at a time in image order.
  task automatic build_expected(input int len, input int cnt);
    beat_t      b;
    int         n;
    int         col;
    logic [1:0] tag;
    n = len * cnt;
    b.data  = '0;
    b.count = 0;
    for (int k = 0; k < n; k++) begin
      col = k % len;
      if (len == 1)            tag = 2'b11;
      else if (col == 0)       tag = 2'b10;
      else if (col == len - 1) tag = 2'b01;
      else                     tag = 2'b00;
      b.data[b.count*WW +: WW] = {tag, pix_q[k]};
      b.count++;
      if (b.count == PW || k == n - 1) begin
        exp_q.push_back(b);
        b.data  = '0;
        b.count = 0;
      end
    end
  endtask

  task automatic prepImage(input int len, input int cnt, input bit ramp);
    pix_q.delete();
    beats_seen = 0;
    done_seen  = 0;
    last_count = 0;
    for (int k = 0; k < len * cnt; k++) pix_q.push_back(ramp ? DW'(k + 1) : DW'($urandom));
    if (len * cnt > 0) build_expected(len, cnt);
  endtask

  task automatic startImage(input int len, input int cnt);
    @(posedge clk); #1;
    row_len = RLS'(len);
    row_cnt = RLS'(cnt);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic feedPixels(input int num, input bit gaps);
    bit accepted;
    for (int k = 0; k < num; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.pixel_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.pixel_valid = 1'b1;
      bus.pixel_in    = pix_q[k];
      accepted = 1'b0;
      for (int t = 0; t < 100 && !accepted; t++) begin
        @(negedge clk);
        accepted = bus.pixel_ready;
        @(posedge clk); #1;
      end
      if (!accepted) begin
        checkOutput("pixel_accept_timeout", 0, 1);
        break;
      end
    end
    bus.pixel_valid = 1'b0;
  endtask

  task automatic waitDone(input int n);
    if (n > 0) begin
      for (int t = 0; t < 400 && done_seen == 0; t++) @(posedge clk);
      if (done_seen == 0) checkOutput("done_timeout", 0, 1);
      repeat (3) @(posedge clk);
    end else begin
      repeat (20) @(posedge clk);
    end
    #1;
  endtask

  task automatic applyStimulus(input int len, input int cnt, input bit ramp, input bit gaps);
    prepImage(len, cnt, ramp);
    startImage(len, cnt);
    feedPixels(len * cnt, gaps);
    waitDone(len * cnt);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{7, 2, 1, 14};
    vecs[1] = '{4, 4, 2, 2};
    vecs[2] = '{1, 3, 1, 3};
    vecs[3] = '{5, 3, 2, 1};
    vecs[4] = '{14, 1, 1, 14};
    vecs[5] = '{0, 3, 0, 0};
    vecs[6] = '{3, 0, 0, 0};

    rst = 1'b1;
    start = 1'b0;
    row_len = '0;
    row_cnt = '0;
    bus.pixel_in = '0;
    bus.pixel_valid = 1'b0;
    bus.buf_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", BW'(bus.pixel_ready), 0);
    checkOutput("reset_wen", BW'(bus.wen_IFMap_buffer), 0);
    checkOutput("reset_done", BW'(done), 0);
    checkOutput("reset_err", BW'(err), 0);
    checkOutput("reset_wr_count", BW'(bus.wr_count), 0);
    checkOutput("reset_ifmap", bus.IFMap_out, 0);
    rst = 1'b0;

    $display("[TB] vector table");
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].len, vecs[v].cnt, 1'b1, 1'b0);
      checkOutput("vec_beats", BW'(beats_seen), BW'(vecs[v].exp_beats));
      checkOutput("vec_last_count", BW'(last_count), BW'(vecs[v].exp_last_count));
      checkOutput("vec_done", BW'(done_seen), BW'(vecs[v].exp_beats > 0 ? 1 : 0));
      checkOutput("vec_queue_drained", BW'(exp_q.size()), 0);
      checkOutput("vec_idle_ready", BW'(bus.pixel_ready), 0);
      if (v == 0) begin
        checkOutput("full_slot0", BW'(first_beat[0*WW +: WW]), BW'({2'b10, 16'd1}));
        checkOutput("full_slot6", BW'(first_beat[6*WW +: WW]), BW'({2'b01, 16'd7}));
        checkOutput("full_slot7", BW'(first_beat[7*WW +: WW]), BW'({2'b10, 16'd8}));
        checkOutput("full_slot13", BW'(first_beat[13*WW +: WW]), BW'({2'b01, 16'd14}));
      end
      if (v == 1) checkOutput("partial_upper_zero", last_beat >> (2 * WW), 0);
    end

    $display("[TB] backpressure");
    prepImage(4, 1, 1'b1);
    bus.buf_full = 1'b1;
    startImage(4, 1);
    feedPixels(4, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_wen_low", BW'(bus.wen_IFMap_buffer), 0);
      checkOutput("bp_ready_low", BW'(bus.pixel_ready), 0);
      checkOutput("bp_ifmap_stable", bus.IFMap_out, exp_q[0].data);
      @(posedge clk); #1;
    end
    bus.buf_full = 1'b0;
    @(negedge clk);
    checkOutput("bp_wen_release", BW'(bus.wen_IFMap_buffer), 1);
    waitDone(4);
    checkOutput("bp_done", BW'(done_seen), 1);

    $display("[TB] reset mid-image");
    prepImage(7, 2, 1'b1);
    startImage(7, 2);
    feedPixels(5, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_ready", BW'(bus.pixel_ready), 0);
    checkOutput("midrst_wen", BW'(bus.wen_IFMap_buffer), 0);
    checkOutput("midrst_done", BW'(done), 0);
    checkOutput("midrst_err", BW'(err), 0);
    checkOutput("midrst_wr_count", BW'(bus.wr_count), 0);
    checkOutput("midrst_ifmap", bus.IFMap_out, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(7, 2, 1'b1, 1'b0);
    checkOutput("midrst_repack_beats", BW'(beats_seen), 1);
    checkOutput("midrst_repack_slot0", BW'(first_beat[0 +: WW]), BW'({2'b10, 16'd1}));

    $display("[TB] random images");
    rand_bp = 1'b1;
    for (int r = 0; r < 20; r++) begin
      applyStimulus($urandom_range(1, 8), $urandom_range(1, 5), 1'b0, 1'b1);
      checkOutput("rand_queue_drained", BW'(exp_q.size()), 0);
      checkOutput("rand_done", BW'(done_seen), 1);
    end
    rand_bp = 1'b0;
    @(posedge clk); #2;
    bus.buf_full = 1'b0;

    $display("[TB] error flag");
    bus.pixel_valid = 1'b1;
    @(posedge clk); #1;
    bus.pixel_valid = 1'b0;
    checkOutput("err_set", BW'(err), BW'(ERR_EXP));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("err_held", BW'(err), BW'(ERR_EXP));
    rst = 1'b1;
    #1;
    checkOutput("err_cleared", BW'(err), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
